// File: rtl/task_2_input.sv
// Ingress buffer for the task 2 core: collects one fixed-size packet from the
// task manager into a FWFT FIFO, checks its framing, then streams it to the core.
module task_2_input #(
   parameter logic [11:0] PKT_SIZE_IN_BYTES = 12'd64,
   parameter int unsigned FIFO_DEPTH        = 64,
   parameter int unsigned ADDR_W            = 6
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_tmanager_data,
   input  logic        i_tmanager_valid,
   input  logic        i_tmanager_last,
   output logic        o_ttask_ready,
   output logic [7:0]  o_data,
   output logic        o_data_valid,
   output logic        o_input_last,
   input  logic        i_core_ready,
   output logic        o_busy,
   output logic        o_pkt_error,
   output logic [11:0] o_byte_count
);

   // Handshakes: a manager byte moves on i_tmanager_valid && o_ttask_ready,
   // a core byte moves on o_data_valid && i_core_ready; both sampled at posedge.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RECEIVE = 3'd1,
      ST_DRAIN   = 3'd2,
      ST_ERROR   = 3'd3,
      ST_FLUSH   = 3'd4
   } state_e;

   state_e            state_q;
   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [ADDR_W:0]   occ_q;
   logic [11:0]       byte_cnt_q;
   logic              pkt_err_q;

   logic              ready_int;
   logic              accept;
   logic              wr_en;
   logic              drain_valid;
   logic              drain_last;
   logic              xfer;
   logic              size_hit;
   logic [11:0]       byte_cnt_d;

   assign ready_int   = (state_q == ST_IDLE) || (state_q == ST_RECEIVE) ||
                        (state_q == ST_ERROR);
   assign accept      = i_tmanager_valid && ready_int;
   assign wr_en       = accept && ((state_q == ST_IDLE) || (state_q == ST_RECEIVE));
   assign drain_valid = (state_q == ST_DRAIN) && (occ_q != '0);
   assign drain_last  = drain_valid && (occ_q == (ADDR_W+1)'(1));
   assign xfer        = drain_valid && i_core_ready;

   // Count after this accept; the first byte of a packet always counts as 1.
   assign byte_cnt_d  = (state_q == ST_IDLE) ? 12'd1 : byte_cnt_q + 12'd1;
   assign size_hit    = (byte_cnt_d == PKT_SIZE_IN_BYTES);

   always_ff @(posedge i_clk) begin
      if (!i_rst && wr_en) begin
         mem_q[wr_ptr_q] <= i_tmanager_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         byte_cnt_q <= '0;
         pkt_err_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_RECEIVE: begin
               if (accept) begin
                  wr_ptr_q   <= wr_ptr_q + ADDR_W'(1);
                  occ_q      <= occ_q + (ADDR_W+1)'(1);
                  byte_cnt_q <= byte_cnt_d;
                  if (state_q == ST_IDLE) begin
                     pkt_err_q <= 1'b0;
                  end
                  // A packet still open at the full size is long: trap it before it can overflow.
                  if (i_tmanager_last && size_hit) begin
                     state_q <= ST_DRAIN;
                  end else if (i_tmanager_last) begin
                     pkt_err_q <= 1'b1;
                     state_q   <= ST_FLUSH;
                  end else if (size_hit) begin
                     pkt_err_q <= 1'b1;
                     state_q   <= ST_ERROR;
                  end else begin
                     state_q <= ST_RECEIVE;
                  end
               end
            end
            ST_ERROR: begin
               if (accept && i_tmanager_last) begin
                  state_q <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               wr_ptr_q   <= '0;
               rd_ptr_q   <= '0;
               occ_q      <= '0;
               byte_cnt_q <= '0;
               state_q    <= ST_IDLE;
            end
            ST_DRAIN: begin
               if (xfer) begin
                  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                  occ_q    <= occ_q - (ADDR_W+1)'(1);
                  if (drain_last) begin
                     byte_cnt_q <= '0;
                     state_q    <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Every output is forced low while reset is asserted.
   assign o_ttask_ready = !i_rst && ready_int;
   assign o_data        = i_rst ? 8'h00 : mem_q[rd_ptr_q];
   assign o_data_valid  = !i_rst && drain_valid;
   assign o_input_last  = !i_rst && drain_last;
   assign o_busy        = !i_rst && ((state_q == ST_RECEIVE) || (state_q == ST_DRAIN) ||
                                     (state_q == ST_ERROR));
   assign o_pkt_error   = !i_rst && pkt_err_q;
   assign o_byte_count  = i_rst ? 12'd0 : byte_cnt_q;

endmodule

// File: doc/task_2_input.md
Name: task_2_input

Overview:
- Ingress counterpart to the task 2 output path.
- Accepts one fixed-size byte packet from the task manager over a valid/ready/last stream and buffers it in an internal FIFO.
- Once the whole packet is present and correctly framed, streams it to the task 2 core with valid/last, honouring core backpressure.
- Framing errors (short or long packets) are detected, the packet is discarded, and the error is flagged.

Parameters:
- PKT_SIZE_IN_BYTES, 12'd64, exact packet length; legal range 1..FIFO_DEPTH.
- FIFO_DEPTH, 64, buffer depth in bytes; power of two.
- ADDR_W, 6, log2(FIFO_DEPTH).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_tmanager_data  in  8  byte from task manager.
- i_tmanager_valid  in  1  byte valid.
- i_tmanager_last  in  1  marks final byte of the manager packet.
- o_ttask_ready  out  1  block accepts a manager byte this cycle.
- o_data  out  8  byte to core.
- o_data_valid  out  1  o_data valid.
- o_input_last  out  1  final byte of the packet to the core.
- i_core_ready  in  1  core accepts o_data.
- o_busy  out  1  packet in progress (RECEIVE, DRAIN or ERROR).
- o_pkt_error  out  1  sticky framing-error flag.
- o_byte_count  out  12  bytes accepted in the current packet.

Behaviour:
- One clock domain. Reset is synchronous and active-high. Reset overrides everything, including mid-packet:
  - state goes to IDLE; FIFO pointers, occupancy and o_byte_count go to 0; o_pkt_error goes to 0.
  - while i_rst is high, all outputs are 0.
- Handshakes:
  - Manager accept: i_tmanager_valid && o_ttask_ready.
  - Core transfer: o_data_valid && i_core_ready.
- FIFO: first-word-fall-through. o_data = mem[rd_ptr], combinational. Writes occur only on an accept in IDLE/RECEIVE. Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, RECEIVE, DRAIN, ERROR, FLUSH.
- IDLE:
  - o_ttask_ready=1, o_busy=0.
  - On accept: write byte, o_byte_count<=1, clear o_pkt_error.
  - If last && PKT_SIZE==1, go to DRAIN. If last && PKT_SIZE>1, set error and go to FLUSH. Otherwise go to RECEIVE.
- RECEIVE:
  - o_ttask_ready=1. Each accept writes the byte and increments o_byte_count.
  - Let n be o_byte_count after the increment. On accept:
    - last && n==PKT_SIZE: go to DRAIN.
    - last && n<PKT_SIZE (short): set o_pkt_error, go to FLUSH.
    - !last && n==PKT_SIZE (long): set o_pkt_error, go to ERROR.
  - No accept: stay.
- ERROR:
  - o_ttask_ready=1; bytes are accepted and discarded, not written.
  - On an accept with last, go to FLUSH.
- FLUSH:
  - Single cycle, o_ttask_ready=0.
  - Resets FIFO pointers and o_byte_count, then goes to IDLE. o_pkt_error stays set.
- DRAIN:
  - o_ttask_ready=0; o_data_valid = !fifo_empty.
  - o_input_last = o_data_valid && occupancy==1.
  - Each transfer advances rd_ptr.
  - A transfer with o_input_last returns to IDLE the next cycle; o_byte_count<=0.
  - i_core_ready low holds o_data, o_data_valid and o_input_last stable.
- o_data_valid and o_input_last are 0 in every state except DRAIN.
- Latency:
  - First byte is offered to the core the cycle after the accept of the last manager byte.
  - With i_core_ready held high, the packet drains in PKT_SIZE consecutive cycles.
  - o_ttask_ready is high in the first cycle after the drain completes.
- Overflow is impossible because PKT_SIZE<=FIFO_DEPTH; a long packet is trapped at n==PKT_SIZE.
- Manager bytes presented while o_ttask_ready=0 are not consumed; the manager must hold them.

Test Plan:
- Reset, then 64 bytes 0x00..0x3F with last on byte 64, core ready high -> o_data_valid rises the next cycle; bytes 0x00..0x3F on consecutive cycles; o_input_last only with 0x3F; o_pkt_error=0.
- Same packet, i_core_ready toggled 1/0 every cycle -> data order preserved and held stable while stalled; 64 transfers; exactly one o_input_last.
- Short packet: last on byte 10 -> o_pkt_error=1; no o_data_valid; o_ttask_ready low for 1 cycle (FLUSH), then IDLE; next good packet streams correctly and clears o_pkt_error on its first byte.
- Long packet: 70 bytes, last on byte 70 -> error set at byte 64; bytes 65..70 accepted but not written; IDLE after the FLUSH cycle; nothing reaches the core.
- Manager valid held high during DRAIN -> o_ttask_ready=0 throughout, no writes; the next packet is accepted immediately after drain completes.
- i_rst pulsed for 1 cycle mid-RECEIVE (byte 30) and mid-DRAIN (byte 20) -> all outputs 0 during reset; IDLE, o_byte_count=0 and empty FIFO afterwards; a following full packet is delivered intact.
